fft_frame_ctrl: RTL

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

---
 rtl/fft_pkg.sv | 14 +
 rtl/fft_frame_ctrl_if.sv | 32 +++
 rtl/fft_ctrl_dly.sv | 40 ++++
 rtl/fft_frame_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared state type and default sizing for the FFT frame controller.
package fft_pkg;

    localparam int FFT_LOG2N     = 5;
    localparam int FFT_STAGE_LAT = 2;
    localparam int FFT_N         = 1 << FFT_LOG2N;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fft_state_e;

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// Sample handshake and per-stage control bundle between the frame controller
// and the butterfly pipeline it sequences.
interface fft_frame_ctrl_if #(
    parameter int LOG2N = fft_pkg::FFT_LOG2N
) ();

    logic                         in_valid;
    logic [LOG2N*LOG2N-1:0]       stage_idx;
    logic [LOG2N-1:0]             stage_en;
    logic [LOG2N*(LOG2N-1)-1:0]   tw_addr;
    logic                         out_valid;
    logic                         frame_start;
    logic                         frame_done;
    logic                         err_gap;
    logic                         busy;
    logic [7:0]                   frame_cnt;

    // Sample source side: drives in_valid, observes the controller.
    modport master (
        output in_valid,
        input  stage_idx, stage_en, tw_addr, out_valid,
        input  frame_start, frame_done, err_gap, busy, frame_cnt
    );

    // Controller side.
    modport slave (
        input  in_valid,
        output stage_idx, stage_en, tw_addr, out_valid,
        output frame_start, frame_done, err_gap, busy, frame_cnt
    );

endinterface

// File: rtl/fft_ctrl_dly.sv
// Fixed-depth {valid, idx} shift register with a synchronous flush used to
// carry sample tags alongside the butterfly datapath.
module fft_ctrl_dly #(
    parameter int DEPTH = 2,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr_i,
    input  logic         vld_i,
    input  logic [W-1:0] idx_i,
    output logic         vld_o,
    output logic [W-1:0] idx_o
);

    logic [DEPTH-1:0] vld_q;
    logic [W-1:0]     idx_q [DEPTH];

    // Shift the tag one slot per cycle; a clear empties every slot at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
        end else if (clr_i) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
        end else begin
            vld_q[0] <= vld_i;
            idx_q[0] <= idx_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign idx_o = idx_q[DEPTH-1];

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for a pipelined radix-2 DIF FFT: numbers incoming samples,
// tracks frame boundaries and drains, and fans tagged indices out to every
// butterfly stage together with that stage's twiddle ROM address.
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2N     = FFT_LOG2N,
    parameter int STAGE_LAT = FFT_STAGE_LAT
) (
    input  logic            clk,
    input  logic            rstn,
    fft_frame_ctrl_if.slave bus
);

    localparam int N         = 1 << LOG2N;
    localparam int FLUSH_CYC = LOG2N * STAGE_LAT;
    localparam int FCW       = $clog2(FLUSH_CYC + 1);
    localparam int TWW       = LOG2N - 1;

    fft_state_e       state_q, state_d;
    logic [LOG2N-1:0] idx_q, idx_d;
    logic [FCW-1:0]   flush_q, flush_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             start_c, gap_c, done_c;
    logic [LOG2N-1:0] acc_idx;
    logic [LOG2N-1:0] stg_vld;
    logic [LOG2N-1:0] stg_idx [LOG2N];
    logic             out_vld;
    logic [LOG2N-1:0] out_idx;

    // Sequencer state, input sample counter and drain timer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            flush_q <= flush_d;
        end
    end

    // Next state: every in_valid is accepted; a drop mid-frame aborts, a drop
    // on a frame boundary drains the pipeline before returning to idle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        flush_d = flush_q;
        start_c = 1'b0;
        gap_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    start_c = 1'b1;
                    idx_d   = LOG2N'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.in_valid) begin
                    start_c = (idx_q == '0);
                    idx_d   = idx_q + 1'b1;
                end else if (idx_q != '0) begin
                    gap_c   = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    flush_d = '0;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (bus.in_valid) begin
                    start_c = 1'b1;
                    idx_d   = LOG2N'(1);
                    state_d = RUN;
                end else if (flush_q == FCW'(FLUSH_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outside RUN the counter sits at 0, so the accepted index is idx_q;
    // idle slots carry index 0 so unqualified stage outputs stay quiet.
    assign acc_idx = bus.in_valid ? idx_q : '0;

    fft_ctrl_dly #(.DEPTH(1), .W(LOG2N)) u_stg0 (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (gap_c),
        .vld_i (bus.in_valid),
        .idx_i (acc_idx),
        .vld_o (stg_vld[0]),
        .idx_o (stg_idx[0])
    );

    for (genvar s = 1; s < LOG2N; s++) begin : g_stg
        fft_ctrl_dly #(.DEPTH(STAGE_LAT), .W(LOG2N)) u_stg (
            .clk   (clk),
            .rstn  (rstn),
            .clr_i (gap_c),
            .vld_i (stg_vld[s-1]),
            .idx_i (stg_idx[s-1]),
            .vld_o (stg_vld[s]),
            .idx_o (stg_idx[s])
        );
    end

    fft_ctrl_dly #(.DEPTH(STAGE_LAT), .W(LOG2N)) u_out (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (gap_c),
        .vld_i (stg_vld[LOG2N-1]),
        .idx_i (stg_idx[LOG2N-1]),
        .vld_o (out_vld),
        .idx_o (out_idx)
    );

    // DIF twiddle: keep the low (LOG2N-1-s) index bits, scale by 2^s.
    for (genvar s = 0; s < LOG2N; s++) begin : g_tw
        localparam logic [LOG2N-1:0] MASK = LOG2N'((1 << (TWW - s)) - 1);
        assign bus.stage_idx[s*LOG2N +: LOG2N] = stg_idx[s];
        assign bus.tw_addr[s*TWW +: TWW]       = TWW'(stg_idx[s] & MASK) << s;
    end

    // The visible count already includes a frame finishing this cycle.
    assign done_c      = out_vld && (out_idx == LOG2N'(N - 1));
    assign frame_cnt_d = frame_cnt_q + {7'd0, done_c};

    // Completed-frame counter, wrapping at 256.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) frame_cnt_q <= '0;
        else       frame_cnt_q <= frame_cnt_d;
    end

    // frame_start depends on in_valid directly, so it is held low in reset.
    assign bus.frame_start = start_c & rstn;
    assign bus.err_gap     = gap_c;
    assign bus.busy        = (state_q != IDLE);
    assign bus.stage_en    = stg_vld;
    assign bus.out_valid   = out_vld;
    assign bus.frame_done  = done_c;
    assign bus.frame_cnt   = frame_cnt_d;

endmodule
